usb_host_tx: RTL and testbench



---
 rtl/usb_host_tx_pkg.sv | 25 ++
 rtl/usb_host_tx_if.sv | 26 ++
 rtl/usb_tx_stuff_nrzi.sv | 52 +++++
 rtl/usb_host_tx.sv | 130 +++++++++++++
 tb/tb_usb_host_tx.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/usb_host_tx_pkg.sv
// Shared constants and types for the host-side USB full-speed transmitter.
// Line states are packed as {dp, dn}.
package usb_host_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        DATA,
        EOP
    } tx_state_t;

    localparam logic [1:0] LS_J   = 2'b10;
    localparam logic [1:0] LS_K   = 2'b01;
    localparam logic [1:0] LS_SE0 = 2'b00;

    localparam logic [7:0] SYNC_PATTERN = 8'h80;
    localparam int         EOP_SE0_BITS = 2;
    localparam int         STUFF_LIMIT  = 6;

    // NRZI level 1 means the line currently sits at J.
    function automatic logic [1:0] nrzi_line(input logic level);
        return level ? LS_J : LS_K;
    endfunction

endpackage

// File: rtl/usb_host_tx_if.sv
// Byte stream handshake between a packet source and the USB host transmitter.
interface usb_host_tx_if;

    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_last;
    logic       tx_ready;
    logic       tx_underrun;

    modport master (
        output tx_valid,
        output tx_data,
        output tx_last,
        input  tx_ready,
        input  tx_underrun
    );

    modport slave (
        input  tx_valid,
        input  tx_data,
        input  tx_last,
        output tx_ready,
        output tx_underrun
    );

endinterface

// File: rtl/usb_tx_stuff_nrzi.sv
// Bit stuffer and NRZI encoder: turns one raw bit per strobe into a registered line state.
// hold tells the caller that the coming slot carries a stuffed 0 rather than its data bit.
module usb_tx_stuff_nrzi
    import usb_host_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       strobe,
    input  logic       data_bit,
    input  logic       se0_req,
    input  logic       j_req,
    input  logic       idle_req,
    output logic       hold,
    output logic [1:0] line,
    output logic       tx_en
);

    logic       level;
    logic [2:0] ones;
    logic       coded_bit;
    logic       next_level;

    assign hold       = (ones == 3'(STUFF_LIMIT));
    assign coded_bit  = hold ? 1'b0 : data_bit;
    assign next_level = coded_bit ? level : ~level;

    // SE0 and J slots also re-arm the encoder so the next packet starts from J with no run of ones.
    always_ff @(posedge clk) begin
        if (reset || idle_req) begin
            level <= 1'b1;
            ones  <= 3'd0;
            line  <= LS_J;
            tx_en <= 1'b0;
        end else if (strobe) begin
            tx_en <= 1'b1;
            if (se0_req) begin
                line  <= LS_SE0;
                level <= 1'b1;
                ones  <= 3'd0;
            end else if (j_req) begin
                line  <= LS_J;
                level <= 1'b1;
                ones  <= 3'd0;
            end else begin
                line  <= nrzi_line(next_level);
                level <= next_level;
                ones  <= coded_bit ? ones + 3'd1 : 3'd0;
            end
        end
    end

endmodule

// File: rtl/usb_host_tx.sv
// Host-side USB full-speed packet transmitter: SYNC, bit-stuffed NRZI payload, EOP.
// Bytes arrive on a valid/ready stream and are sent LSB first.
module usb_host_tx
    import usb_host_pkg::*;
#(
    parameter int BIT_CYCLES = 4
) (
    input  logic         clk48_host,
    input  logic         reset,
    usb_host_tx_if.slave tx,
    output logic         busy,
    output logic         usb_dp_o,
    output logic         usb_dn_o,
    output logic         usb_tx_en
);

    localparam int                 PHASE_W     = $clog2(BIT_CYCLES);
    localparam logic [PHASE_W-1:0] PHASE_LAST  = PHASE_W'(BIT_CYCLES - 1);
    localparam logic [2:0]         EOP_J_CNT   = 3'(EOP_SE0_BITS - 1);
    localparam logic [2:0]         EOP_END_CNT = 3'(EOP_SE0_BITS);

    tx_state_t          state;
    logic [PHASE_W-1:0] phase;
    logic [2:0]         bit_cnt;
    logic [6:0]         shift_reg;
    logic               last_flag;
    logic               underrun_q;

    logic       hold;
    logic [1:0] line;
    logic       bit_end;
    logic       field_end;
    logic       load;
    logic       take;
    logic       start;
    logic       eop_done;
    logic       strobe;
    logic       data_bit;
    logic       se0_req;
    logic       j_req;
    logic       idle_req;

    // field_end waits out a pending stuffed bit, so stuffing always precedes a load or EOP.
    assign bit_end   = (state != IDLE) && (phase == PHASE_LAST);
    assign field_end = bit_end && !hold && (bit_cnt == 3'd7) && (state == SYNC || state == DATA);
    assign load      = field_end && (state == SYNC || !last_flag);
    assign take      = load && tx.tx_valid;
    assign start     = (state == IDLE) && tx.tx_valid;
    assign eop_done  = (state == EOP) && bit_end && (bit_cnt == EOP_END_CNT);

    assign strobe   = start || bit_end;
    assign data_bit = take ? tx.tx_data[0] : (start ? SYNC_PATTERN[0] : shift_reg[0]);
    assign se0_req  = (field_end && !take) || (state == EOP && bit_cnt < EOP_J_CNT);
    assign j_req    = (state == EOP) && (bit_cnt == EOP_J_CNT);
    assign idle_req = ((state == IDLE) && !tx.tx_valid) || eop_done;

    assign tx.tx_ready    = take;
    assign tx.tx_underrun = underrun_q;
    assign busy           = (state != IDLE);
    assign usb_dp_o       = line[1];
    assign usb_dn_o       = line[0];

    // shift_reg holds the not-yet-sent bits of the current field; bit 0 goes out on the next advance.
    always_ff @(posedge clk48_host) begin
        if (reset) begin
            state      <= IDLE;
            phase      <= '0;
            bit_cnt    <= 3'd0;
            shift_reg  <= 7'd0;
            last_flag  <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            underrun_q <= 1'b0;
            phase      <= (state == IDLE || bit_end) ? '0 : phase + PHASE_W'(1);
            case (state)
                IDLE: begin
                    bit_cnt <= 3'd0;
                    if (tx.tx_valid) begin
                        state     <= SYNC;
                        shift_reg <= SYNC_PATTERN[7:1];
                        last_flag <= 1'b0;
                    end
                end
                SYNC, DATA: begin
                    if (bit_end && !hold) begin
                        if (bit_cnt == 3'd7) begin
                            bit_cnt <= 3'd0;
                            if (take) begin
                                state     <= DATA;
                                shift_reg <= tx.tx_data[7:1];
                                last_flag <= tx.tx_last;
                            end else begin
                                state      <= EOP;
                                underrun_q <= load;
                            end
                        end else begin
                            bit_cnt   <= bit_cnt + 3'd1;
                            shift_reg <= {1'b0, shift_reg[6:1]};
                        end
                    end
                end
                EOP: begin
                    if (bit_end) begin
                        if (eop_done) begin
                            state   <= IDLE;
                            bit_cnt <= 3'd0;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    usb_tx_stuff_nrzi u_stuff_nrzi (
        .clk      (clk48_host),
        .reset    (reset),
        .strobe   (strobe),
        .data_bit (data_bit),
        .se0_req  (se0_req),
        .j_req    (j_req),
        .idle_req (idle_req),
        .hold     (hold),
        .line     (line),
        .tx_en    (usb_tx_en)
    );

endmodule

// File: tb/tb_usb_host_tx.sv
// Directed bench for usb_host_tx: a line-level model fills scoreboard queues, the monitor pops and compares.
module tb_usb_host_tx;
    import usb_host_pkg::*;

    typedef logic [7:0] byte_q_t[$];

    logic clk48_host = 1'b0;
    logic reset      = 1'b1;
    logic busy;
    logic usb_dp_o;
    logic usb_dn_o;
    logic usb_tx_en;

    usb_host_tx_if tx_if();

    usb_host_tx #(.BIT_CYCLES(4)) dut (
        .clk48_host (clk48_host),
        .reset      (reset),
        .tx         (tx_if),
        .busy       (busy),
        .usb_dp_o   (usb_dp_o),
        .usb_dn_o   (usb_dn_o),
        .usb_tx_en  (usb_tx_en)
    );

    always #5 clk48_host = ~clk48_host;

    int n_checks = 0;
    int n_fail   = 0;

    logic [8:0] src_q[$];
    logic [1:0] exp_line_q[$];
    int         exp_ready_q[$];
    int         exp_len_q[$];
    int         exp_nready_q[$];

    logic m_lvl;
    int   m_ones;
    int   m_nbits;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Source: offers the queue head each cycle and retires it once the DUT accepts it.
    initial begin
        tx_if.tx_valid = 1'b0;
        tx_if.tx_data  = 8'h00;
        tx_if.tx_last  = 1'b0;
        forever begin
            @(negedge clk48_host);
            if (src_q.size() > 0) begin
                tx_if.tx_valid = 1'b1;
                tx_if.tx_data  = src_q[0][7:0];
                tx_if.tx_last  = src_q[0][8];
            end else begin
                tx_if.tx_valid = 1'b0;
                tx_if.tx_data  = 8'h00;
                tx_if.tx_last  = 1'b0;
            end
            #1;
            if (tx_if.tx_valid === 1'b1 && tx_if.tx_ready === 1'b1)
                void'(src_q.pop_front());
        end
    end

    task automatic model_bit(input logic b);
        if (!b) m_lvl = ~m_lvl;
        m_ones = b ? m_ones + 1 : 0;
        exp_line_q.push_back(m_lvl ? 2'b10 : 2'b01);
        m_nbits++;
    endtask

    task automatic apply_stimulus(input byte_q_t bytes, input logic mark_last);
        m_lvl   = 1'b1;
        m_ones  = 0;
        m_nbits = 0;
        for (int i = 0; i < 8; i++) model_bit(i == 7);
        for (int b = 0; b < bytes.size(); b++) begin
            logic [7:0] v;
            v = bytes[b];
            for (int i = 0; i < 8; i++) begin
                if (m_ones == 6) model_bit(1'b0);
                if (i == 0) exp_ready_q.push_back(4 * m_nbits - 1);
                model_bit(v[i]);
            end
            src_q.push_back({mark_last && (b == bytes.size() - 1), v});
        end
        if (m_ones == 6) model_bit(1'b0);
        exp_line_q.push_back(2'b00);
        exp_line_q.push_back(2'b00);
        exp_line_q.push_back(2'b10);
        m_nbits += 3;
        exp_len_q.push_back(4 * m_nbits);
        exp_nready_q.push_back(bytes.size());
    endtask

    task automatic check_output(input string tag, input int exp_underruns, output int waited);
        int         cyc;
        int         underruns;
        int         nready;
        int         exp_len;
        int         exp_nready;
        int         exp_off;
        logic [1:0] cur;
        exp_len    = (exp_len_q.size() > 0) ? exp_len_q.pop_front() : -1;
        exp_nready = (exp_nready_q.size() > 0) ? exp_nready_q.pop_front() : -1;
        waited     = 0;
        cyc        = 0;
        underruns  = 0;
        nready     = 0;
        cur        = 2'b11;
        @(negedge clk48_host); #2;
        while (usb_tx_en !== 1'b1 && waited < 300) begin
            waited++;
            @(negedge clk48_host); #2;
        end
        check({tag, "_start"}, 32'(usb_tx_en), 32'd1);
        check({tag, "_busy_hi"}, 32'(busy), 32'd1);
        while (usb_tx_en === 1'b1 && cyc < 400) begin
            if (cyc % 4 == 0) cur = (exp_line_q.size() > 0) ? exp_line_q.pop_front() : 2'b11;
            check($sformatf("%s_line_c%0d", tag, cyc), 32'({usb_dp_o, usb_dn_o}), 32'(cur));
            if (tx_if.tx_ready === 1'b1) begin
                nready++;
                exp_off = (exp_ready_q.size() > 0) ? exp_ready_q.pop_front() : -1;
                check({tag, "_ready_cycle"}, 32'(cyc), 32'(exp_off));
            end
            if (tx_if.tx_underrun === 1'b1) underruns++;
            cyc++;
            @(negedge clk48_host); #2;
        end
        check({tag, "_en_cycles"}, 32'(cyc), 32'(exp_len));
        check({tag, "_ready_count"}, 32'(nready), 32'(exp_nready));
        check({tag, "_underruns"}, 32'(underruns), 32'(exp_underruns));
        check({tag, "_busy_lo"}, 32'(busy), 32'd0);
        check({tag, "_idle_J"}, 32'({usb_dp_o, usb_dn_o}), 32'(2'b10));
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        byte_q_t bq;
        int      waited;
        int      w;

        reset = 1'b1;
        repeat (3) @(negedge clk48_host);
        #2;
        check("rst_tx_en", 32'(usb_tx_en), 32'd0);
        check("rst_dp", 32'(usb_dp_o), 32'd1);
        check("rst_dn", 32'(usb_dn_o), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(tx_if.tx_ready), 32'd0);
        check("rst_underrun", 32'(tx_if.tx_underrun), 32'd0);
        @(negedge clk48_host);
        reset = 1'b0;

        $display("[TB] single byte 0x00");
        bq = {8'h00};
        apply_stimulus(bq, 1'b1);
        check_output("b00", 0, waited);

        $display("[TB] single byte 0xFF (stuffing)");
        bq = {8'hFF};
        apply_stimulus(bq, 1'b1);
        check_output("bff", 0, waited);

        $display("[TB] streamed 0xA5 0x12");
        bq = {8'hA5, 8'h12};
        apply_stimulus(bq, 1'b1);
        check_output("a512", 0, waited);

        $display("[TB] underrun after 0x3C");
        bq = {8'h3C};
        apply_stimulus(bq, 1'b0);
        check_output("undr", 1, waited);

        $display("[TB] reset in the middle of DATA");
        src_q.push_back({1'b1, 8'h55});
        w = 0;
        while (usb_tx_en !== 1'b1 && w < 300) begin
            w++;
            @(negedge clk48_host); #2;
        end
        check("midrst_start", 32'(usb_tx_en), 32'd1);
        repeat (40) @(negedge clk48_host);
        reset = 1'b1;
        @(negedge clk48_host); #2;
        check("midrst_tx_en", 32'(usb_tx_en), 32'd0);
        check("midrst_line", 32'({usb_dp_o, usb_dn_o}), 32'(2'b10));
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_ready", 32'(tx_if.tx_ready), 32'd0);
        src_q.delete();
        reset = 1'b0;

        bq = {8'h00};
        apply_stimulus(bq, 1'b1);
        check_output("post_rst", 0, waited);

        $display("[TB] back-to-back packets");
        bq = {8'h81};
        apply_stimulus(bq, 1'b1);
        bq = {8'h7E};
        apply_stimulus(bq, 1'b1);
        check_output("b2b_1", 0, waited);
        check_output("b2b_2", 0, waited);
        check("b2b_gap_bounded", 32'(waited <= 3), 32'd1);

        check("lines_drained", 32'(exp_line_q.size()), 32'd0);
        check("ready_drained", 32'(exp_ready_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
